// File: rtl/core_logic_prog_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | core_logic_prog_pkg: shared defaults and cfg_data field offsets for the    |
// | programmable core FSM and its table loader.  Rev 1.0                       |
// +----------------------------------------------------------------------------+
package core_logic_prog_pkg;

    localparam int          DEF_STATE_W = 4;
    localparam int          DEF_COND_W  = 4;
    localparam logic [15:0] DEF_POLY    = 16'h1021;

    // cfg_data = {valid, mask, value, next}, next at bit 0
    localparam int NEXT_LSB = 0;

    function automatic int value_lsb(input int state_w);
        return state_w;
    endfunction

    function automatic int mask_lsb(input int state_w, input int cond_w);
        return state_w + cond_w;
    endfunction

    function automatic int valid_b(input int state_w, input int cond_w);
        return state_w + 2 * cond_w;
    endfunction

endpackage : core_logic_prog_pkg
`default_nettype wire

// File: rtl/core_rule_match.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | core_rule_match: masked-compare of one state's rules against cond; the     |
// | highest-index matching rule supplies the next state.  Rev 1.0              |
// +----------------------------------------------------------------------------+
module core_rule_match
    import core_logic_prog_pkg::*;
#(
    parameter  int STATE_W = DEF_STATE_W,
    parameter  int COND_W  = DEF_COND_W,
    parameter  int RULES   = 4,
    localparam int BODY_W  = 2 * COND_W + STATE_W
) (
    input  logic [RULES-1:0]             valid,
    input  logic [RULES-1:0][BODY_W-1:0] body,
    input  logic [COND_W-1:0]            cond,
    output logic                         hit,
    output logic [STATE_W-1:0]           next
);

    localparam int VALUE_LSB = value_lsb(STATE_W);
    localparam int MASK_LSB  = mask_lsb(STATE_W, COND_W);

    logic [RULES-1:0] w_match;

    for (genvar r = 0; r < RULES; r++) begin : g_rule
        assign w_match[r] = valid[r] &&
            (((cond ^ body[r][VALUE_LSB +: COND_W]) & body[r][MASK_LSB +: COND_W]) == '0);
    end

    // Ascending scan: a later (higher-index) match overrides earlier ones.
    always_comb begin
        hit  = 1'b0;
        next = '0;
        for (int r = 0; r < RULES; r++) begin
            if (w_match[r]) begin
                hit  = 1'b1;
                next = body[r][NEXT_LSB +: STATE_W];
            end
        end
    end

endmodule : core_rule_match
`default_nettype wire

// File: rtl/core_logic_prog.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | core_logic_prog: table-driven core FSM with force-load, enable-clear,      |
// | transition counter and MISR signature of the state stream.  Rev 1.0        |
// +----------------------------------------------------------------------------+
module core_logic_prog
    import core_logic_prog_pkg::*;
#(
    parameter  int               STATE_W = DEF_STATE_W,
    parameter  int               COND_W  = DEF_COND_W,
    parameter  int               RULES   = 4,
    parameter  int               SIG_W   = 16,
    parameter  logic [SIG_W-1:0] POLY    = SIG_W'(DEF_POLY),
    parameter  int               CNT_W   = 16,
    localparam int               RULE_IW = (RULES > 1) ? $clog2(RULES) : 1,
    localparam int               DATA_W  = 1 + 2 * COND_W + STATE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [COND_W:0]    x,
    input  logic               cfg_we,
    input  logic [STATE_W-1:0] cfg_state,
    input  logic [RULE_IW-1:0] cfg_rule,
    input  logic [DATA_W-1:0]  cfg_data,
    input  logic               sig_clr,
    output logic [STATE_W-1:0] y,
    output logic [CNT_W-1:0]   trans_cnt,
    output logic [SIG_W-1:0]   sig
);

    localparam int NSTATES = 2 ** STATE_W;
    localparam int BODY_W  = 2 * COND_W + STATE_W;
    localparam int VALID_B = valid_b(STATE_W, COND_W);

    logic [RULES-1:0]             r_valid [NSTATES];
    logic [RULES-1:0][BODY_W-1:0] r_body  [NSTATES];
    logic [STATE_W-1:0]           r_state;
    logic [CNT_W-1:0]             r_cnt;
    logic [SIG_W-1:0]             r_sig;

    logic                         w_wr_ok;
    logic                         w_hit;
    logic [STATE_W-1:0]           w_rule_next;
    logic [STATE_W-1:0]           w_state_next;
    logic [SIG_W-1:0]             w_sig_step;

    // Rule indices past RULES exist only when RULES is not a power of two.
    assign w_wr_ok = cfg_we && (int'(cfg_rule) < RULES);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NSTATES; s++) begin
                r_valid[s] <= '0;
            end
        end else if (w_wr_ok) begin
            r_valid[cfg_state][cfg_rule] <= cfg_data[VALID_B];
        end
    end

    // Rule bodies are only meaningful behind a valid bit, so they carry no reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_body[cfg_state][cfg_rule] <= cfg_data[BODY_W-1:0];
        end
    end

    core_rule_match #(
        .STATE_W (STATE_W),
        .COND_W  (COND_W),
        .RULES   (RULES)
    ) u_match (
        .valid (r_valid[r_state]),
        .body  (r_body[r_state]),
        .cond  (x[COND_W:1]),
        .hit   (w_hit),
        .next  (w_rule_next)
    );

    always_comb begin
        w_state_next = r_state;
        if (!enable) begin
            w_state_next = '0;
        end else if (x[0]) begin
            w_state_next = x[STATE_W:1];
        end else if (w_hit) begin
            w_state_next = w_rule_next;
        end
    end

    assign w_sig_step = {r_sig[SIG_W-2:0], 1'b0}
                      ^ (r_sig[SIG_W-1] ? POLY : '0)
                      ^ SIG_W'(r_state);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= '0;
            r_cnt   <= '0;
            r_sig   <= '0;
        end else begin
            r_state <= w_state_next;
            if (sig_clr) begin
                r_cnt <= '0;
                r_sig <= '0;
            end else if (enable) begin
                r_sig <= w_sig_step;
                if (w_state_next != r_state) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign y         = r_state;
    assign trans_cnt = r_cnt;
    assign sig       = r_sig;

endmodule : core_logic_prog
`default_nettype wire

// File: tb/tb_core_logic_prog.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_core_logic_prog: scoreboard bench for core_logic_prog (default params). |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_core_logic_prog;

    localparam logic [15:0] C_POLY = 16'h1021;

    typedef struct packed {
        logic [3:0]  y;
        logic [15:0] cnt;
        logic [15:0] sig;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [4:0]  x;
    logic        cfg_we;
    logic [3:0]  cfg_state;
    logic [1:0]  cfg_rule;
    logic [12:0] cfg_data;
    logic        sig_clr;
    logic [3:0]  y;
    logic [15:0] trans_cnt;
    logic [15:0] sig;

    int tests = 0;
    int fails = 0;

    // Reference model: table entries are {valid, mask, value, next}
    logic [12:0] m_tab [16][4];
    logic [3:0]  m_y   = '0;
    logic [15:0] m_cnt = '0;
    logic [15:0] m_sig = '0;
    exp_t        sb_q [$];

    always #5 clk = ~clk;

    core_logic_prog dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .x         (x),
        .cfg_we    (cfg_we),
        .cfg_state (cfg_state),
        .cfg_rule  (cfg_rule),
        .cfg_data  (cfg_data),
        .sig_clr   (sig_clr),
        .y         (y),
        .trans_cnt (trans_cnt),
        .sig       (sig)
    );

    // Monitor: one expected tuple per driven cycle, checked 1 time unit after the edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            tests++;
            if ({y, trans_cnt, sig} !== e) begin
                fails++;
                $display("FAIL scoreboard @%0t: got y=%h cnt=%h sig=%h want y=%h cnt=%h sig=%h",
                         $time, y, trans_cnt, sig, e.y, e.cnt, e.sig);
            end
        end
    end

    // One clock of stimulus; the model advances and its result goes to the scoreboard.
    task automatic step(input logic r, input logic en, input logic [4:0] xv,
                        input logic we, input logic [3:0] st, input logic [1:0] rl,
                        input logic [12:0] d, input logic clr);
        logic [3:0]  ny;
        logic [15:0] nc, ns;
        logic        found;
        @(negedge clk);
        rst = r; enable = en; x = xv; cfg_we = we;
        cfg_state = st; cfg_rule = rl; cfg_data = d; sig_clr = clr;
        if (r) begin
            ny = '0; nc = '0; ns = '0;
            for (int s = 0; s < 16; s++)
                for (int k = 0; k < 4; k++) m_tab[s][k][12] = 1'b0;
        end else begin
            ny = m_y;
            if (!en) ny = '0;
            else if (xv[0]) ny = xv[4:1];
            else begin
                found = 1'b0;
                for (int k = 3; k >= 0; k--) begin
                    if (!found && m_tab[m_y][k][12] === 1'b1 &&
                        (((xv[4:1] ^ m_tab[m_y][k][7:4]) & m_tab[m_y][k][11:8]) == 4'h0)) begin
                        ny = m_tab[m_y][k][3:0];
                        found = 1'b1;
                    end
                end
            end
            ns = m_sig;
            nc = m_cnt;
            if (clr) begin
                ns = '0; nc = '0;
            end else if (en) begin
                ns = {m_sig[14:0], 1'b0} ^ (m_sig[15] ? C_POLY : 16'h0) ^ {12'h0, m_y};
                if (ny != m_y) nc = m_cnt + 16'd1;
            end
            if (we) m_tab[st][rl] = d;
        end
        m_y = ny; m_cnt = nc; m_sig = ns;
        sb_q.push_back('{y: ny, cnt: nc, sig: ns});
        @(posedge clk);
        #2;
    endtask

    task automatic cyc(input logic en, input logic [4:0] xv);
        step(1'b0, en, xv, 1'b0, 4'h0, 2'h0, 13'h0, 1'b0);
    endtask

    task automatic wr(input logic [3:0] st, input logic [1:0] rl, input logic [12:0] d,
                      input logic en, input logic [4:0] xv);
        step(1'b0, en, xv, 1'b1, st, rl, d, 1'b0);
    endtask

    task automatic test_reset;
        step(1'b1, 1'b1, 5'h0, 1'b0, 4'h0, 2'h0, 13'h0, 1'b0);
        step(1'b1, 1'b1, 5'h0, 1'b0, 4'h0, 2'h0, 13'h0, 1'b0);
        cyc(1'b1, 5'b0110_0);
        cyc(1'b1, 5'b1111_0);
        tests++;
        if ({y, trans_cnt, sig} !== 36'h0) begin
            fails++;
            $display("FAIL reset_state: got y=%h cnt=%h sig=%h want all zero", y, trans_cnt, sig);
        end
    endtask

    task automatic test_basic;
        wr(4'h0, 2'd0, {1'b1, 4'hF, 4'h2, 4'h1}, 1'b1, 5'b0000_0);
        cyc(1'b1, 5'b0010_0);
        tests++;
        if (y !== 4'h1 || trans_cnt !== 16'd1) begin
            fails++;
            $display("FAIL basic_rule: got y=%h cnt=%0d want y=1 cnt=1", y, trans_cnt);
        end
    endtask

    task automatic test_priority;
        wr(4'h0, 2'd0, {1'b1, 4'h0, 4'h0, 4'h3}, 1'b0, 5'h0);
        wr(4'h0, 2'd2, {1'b1, 4'hF, 4'h8, 4'h6}, 1'b0, 5'h0);
        cyc(1'b1, 5'b1000_0);
        tests++;
        if (y !== 4'h6) begin
            fails++;
            $display("FAIL priority_high: got y=%h want 6", y);
        end
        cyc(1'b0, 5'h0);
        cyc(1'b1, 5'b1001_0);
        tests++;
        if (y !== 4'h3) begin
            fails++;
            $display("FAIL priority_low: got y=%h want 3", y);
        end
    endtask

    task automatic test_force;
        logic [15:0] c0;
        c0 = m_cnt;
        cyc(1'b1, 5'b1011_1);
        tests++;
        if (y !== 4'hB || trans_cnt !== c0 + 16'd1) begin
            fails++;
            $display("FAIL force_change: got y=%h cnt=%0d want y=b cnt=%0d", y, trans_cnt, c0 + 16'd1);
        end
        cyc(1'b1, 5'b1011_1);
        tests++;
        if (y !== 4'hB || trans_cnt !== c0 + 16'd1) begin
            fails++;
            $display("FAIL force_same: got y=%h cnt=%0d want y=b cnt=%0d", y, trans_cnt, c0 + 16'd1);
        end
    endtask

    task automatic test_enable_clear;
        logic [15:0] c0, s0;
        cyc(1'b0, 5'h0);
        cyc(1'b1, 5'b1000_0);
        c0 = m_cnt;
        s0 = m_sig;
        cyc(1'b0, 5'b1000_0);
        tests++;
        if (y !== 4'h0 || trans_cnt !== c0 || sig !== s0) begin
            fails++;
            $display("FAIL enable_clear: got y=%h cnt=%h sig=%h want y=0 cnt=%h sig=%h",
                     y, trans_cnt, sig, c0, s0);
        end
        cyc(1'b1, 5'b1000_0);
        cyc(1'b0, 5'h0);
        cyc(1'b1, 5'b1001_0);
        tests++;
        if (y !== 4'h3) begin
            fails++;
            $display("FAIL table_retained: got y=%h want 3", y);
        end
    endtask

    task automatic test_same_cycle_write;
        cyc(1'b0, 5'h0);
        wr(4'h0, 2'd0, {1'b1, 4'hF, 4'h2, 4'h1}, 1'b0, 5'h0);
        wr(4'h0, 2'd0, {1'b1, 4'hF, 4'h2, 4'h5}, 1'b1, 5'b0010_0);
        tests++;
        if (y !== 4'h1) begin
            fails++;
            $display("FAIL write_old_entry: got y=%h want 1", y);
        end
        cyc(1'b0, 5'h0);
        cyc(1'b1, 5'b0010_0);
        tests++;
        if (y !== 4'h5) begin
            fails++;
            $display("FAIL write_new_entry: got y=%h want 5", y);
        end
    endtask

    task automatic test_misr;
        logic [4:0] seq [8];
        seq = '{5'b0001_0, 5'b0100_0, 5'b0000_0, 5'b1001_1,
                5'b0000_0, 5'b0111_1, 5'b0111_0, 5'b0000_0};
        step(1'b1, 1'b1, 5'h0, 1'b0, 4'h0, 2'h0, 13'h0, 1'b0);
        wr(4'h0, 2'd1, {1'b1, 4'hF, 4'h1, 4'h7}, 1'b0, 5'h0);
        wr(4'h7, 2'd0, {1'b1, 4'hC, 4'h4, 4'h2}, 1'b0, 5'h0);
        step(1'b0, 1'b1, 5'h0, 1'b0, 4'h0, 2'h0, 13'h0, 1'b1);
        foreach (seq[i]) cyc(1'b1, seq[i]);
        tests++;
        if (y !== 4'h2 || trans_cnt !== 16'd5 || sig !== m_sig) begin
            fails++;
            $display("FAIL misr_sequence: got y=%h cnt=%0d sig=%h want y=2 cnt=5 sig=%h",
                     y, trans_cnt, sig, m_sig);
        end
        step(1'b0, 1'b1, 5'b1011_1, 1'b0, 4'h0, 2'h0, 13'h0, 1'b1);
        tests++;
        if (y !== 4'hB || trans_cnt !== 16'd0 || sig !== 16'h0) begin
            fails++;
            $display("FAIL clr_on_transition: got y=%h cnt=%0d sig=%h want y=b cnt=0 sig=0",
                     y, trans_cnt, sig);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 300; i++) begin
            step(1'b0,
                 ($urandom_range(0, 7) != 0),
                 {4'($urandom_range(0, 15)), ($urandom_range(0, 5) == 0)},
                 ($urandom_range(0, 3) == 0),
                 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)),
                 13'($urandom_range(0, 8191)),
                 ($urandom_range(0, 15) == 0));
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; x = '0; cfg_we = 1'b0;
        cfg_state = '0; cfg_rule = '0; cfg_data = '0; sig_clr = 1'b0;
        test_reset();
        test_basic();
        test_priority();
        test_force();
        test_enable_clear();
        test_same_cycle_write();
        test_misr();
        test_back_to_back();
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_core_logic_prog
`default_nettype wire
